key_debounce_pulse: RTL and testbench
=====================================

Name: key_debounce_pulse

Overview:
- Upstream conditioning stage for the push-button input (KEY[0]) that drives the 4-bit toggle-flip-flop counter and BCD display path.
- Synchronises the raw active-low key to Clk and debounces it.
- Emits a single-cycle Pulse per debounced press, which the counter uses as its count enable instead of clocking on the raw key.
- Also provides the debounced key level and a single-cycle release pulse.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable Clk cycles needed to accept a press or a release (10 ms at 50 MHz); legal range 1 .. 2^CNT_W-1
CNT_W, 19, width of the debounce counter
REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (used only with the optional feature)
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with the optional feature)

Ports:
Clk  input  1  system clock; all state updates on its rising edge
Clr  input  1  asynchronous active-high reset
KeyN  input  1  raw push button, active-low, asynchronous to Clk
Level  output  1  debounced key state; 1 = pressed
Pulse  output  1  one-Clk-cycle strobe on each accepted press (and on each auto-repeat)
Release  output  1  one-Clk-cycle strobe on each accepted release

Behaviour:
- Synchroniser: two flops, s1 <= ~KeyN and key_s <= s1. Both reset to 0 (released).
- State machine, encoded in 2 bits:
  - IDLE -> ARM_P when key_s=1; cnt cleared to 0.
  - ARM_P, key_s=0 -> IDLE (bounce rejected; no output).
  - ARM_P, key_s=1 -> cnt+1. When cnt==DEBOUNCE_CYCLES-1: go to HELD, Level<=1, Pulse<=1 for exactly one cycle.
  - HELD -> ARM_R when key_s=0; cnt cleared to 0.
  - ARM_R, key_s=1 -> HELD (glitch rejected). No pulse, Level stays 1.
  - ARM_R, key_s=0 -> cnt+1. When cnt==DEBOUNCE_CYCLES-1: go to IDLE, Level<=0, Release<=1 for exactly one cycle.
- All outputs are registered. No combinational path from KeyN to any output.
- Press latency: count the first rising edge that samples KeyN=0 as edge 1. With KeyN stable low, Pulse is high in the cycle after edge DEBOUNCE_CYCLES+3. Release has the same latency, measured from the first edge that samples KeyN=1.
- Pulse and Release are never high in the same cycle. Neither is ever high for 2 consecutive cycles, except for the auto-repeat case described under Optional Feature.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset:
  - Clr=1 forces IDLE, cnt=0, sync flops=0, and Level=Pulse=Release=0, immediately and independent of Clk.
  - Reset asserted mid-debounce or while HELD discards all progress; no Release is generated.
- Key held through the deassertion of Clr: treated as a new press. Full debounce runs, then one Pulse.
- A bounce shorter than DEBOUNCE_CYCLES in either direction produces no output change.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - A repeat counter (width sufficient for REPEAT_DELAY) is cleared on the ARM_P->HELD transition.
  - It counts every cycle spent in HELD and is frozen during ARM_R.
  - After REPEAT_DELAY cycles in HELD, Pulse fires for one cycle. Thereafter Pulse fires every REPEAT_PERIOD cycles while the key remains in HELD.
  - Leaving to IDLE stops the repeats.
- Undefined: no repeat counter is synthesised, and exactly one Pulse is produced per accepted press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=6):
1. Clr pulse, then KeyN=1 for 10 cycles -> Level=Pulse=Release=0 throughout.
2. Press:
   - Stimulus: KeyN falls and is held low 20 cycles.
   - Required: Pulse high for exactly one cycle, in the cycle after edge 7; Level=1 from that same cycle.
   - Then release (KeyN=1) -> Release high for one cycle after edge 7 of the release; Level=0.
3. Bounce: KeyN low 3 cycles, high 2, low 3, then high -> no Pulse; Level stays 0.
4. Release glitch while HELD: KeyN high for 2 cycles, then low again -> no Release, no second Pulse; Level stays 1.
5. Reset: assert Clr asynchronously (mid-cycle) while HELD -> Level drops to 0 before the next edge and no Release occurs. Deassert Clr with the key still low -> a new Pulse occurs 7 edges later.
6. Auto-repeat (KEY_AUTOREPEAT_EN defined), key held 40 cycles after the first Pulse:
   - Required: repeat Pulses at 20, 26, 32 and 38 cycles after entering HELD.
   - With the macro undefined: only the initial Pulse occurs.

Source files
------------

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
// Synchronises the raw active-low push button to Clk, debounces it in both
// directions and produces a registered debounced level plus one-cycle press
// (Pulse) and release (Release) strobes.
// Optional build macro KEY_AUTOREPEAT_EN: adds an auto-repeat counter so Pulse
// also fires after REPEAT_DELAY cycles held and then every REPEAT_PERIOD cycles.
module key_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic Clk,
    input  logic Clr,
    input  logic KeyN,
    output logic Level,
    output logic Pulse,
    output logic Release
);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1 ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("key_debounce_pulse: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM_P = 2'd1,
        HELD  = 2'd2,
        ARM_R = 2'd3
    } state_t;

    logic             s1;
    logic             key_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             level_n;
    logic             pulse_n;
    logic             release_n;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt, rcnt_n;
    logic          rphase, rphase_n;   // 0: waiting for first repeat, 1: periodic
`endif

    // Two-flop synchroniser, inverted so key_s = 1 means pressed.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            s1    <= 1'b0;
            key_s <= 1'b0;
        end else begin
            s1    <= ~KeyN;
            key_s <= s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state   <= IDLE;
            cnt     <= '0;
            Level   <= 1'b0;
            Pulse   <= 1'b0;
            Release <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt    <= '0;
            rphase  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            Level   <= level_n;
            Pulse   <= pulse_n;
            Release <= release_n;
`ifdef KEY_AUTOREPEAT_EN
            rcnt    <= rcnt_n;
            rphase  <= rphase_n;
`endif
        end
    end

    // Next-state, debounce counter and strobe decode.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = Level;
        pulse_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_n = ARM_P;
                    cnt_n   = '0;
                end
            end
            ARM_P: begin
                if (!key_s) begin
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_n = ARM_R;
                    cnt_n   = '0;
                end
            end
            ARM_R: begin
                if (key_s) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

`ifdef KEY_AUTOREPEAT_EN
        // Repeat timer: restarted on acceptance, advances only while HELD,
        // frozen in ARM_R. After the first repeat it wraps on the period.
        rcnt_n   = rcnt;
        rphase_n = rphase;
        if (state == ARM_P && state_n == HELD) begin
            rcnt_n   = '0;
            rphase_n = 1'b0;
        end else if (state == HELD) begin
            if (rcnt == (rphase ? PER_LAST : DLY_LAST)) begin
                pulse_n  = 1'b1;
                rcnt_n   = '0;
                rphase_n = 1'b1;
            end else begin
                rcnt_n = rcnt + 1'b1;
            end
        end
`endif
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=6). Build with KEY_AUTOREPEAT_EN to exercise auto-repeat.
module tb_key_debounce_pulse;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 6;

    logic Clk;
    logic Clr;
    logic KeyN;
    logic Level;
    logic Pulse;
    logic Release;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .Clk(Clk),
        .Clr(Clr),
        .KeyN(KeyN),
        .Level(Level),
        .Pulse(Pulse),
        .Release(Release)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic l;
        logic p;
        logic r;
    } out_t;

    typedef struct {
        logic        keyn;
        int unsigned cycles;
        int unsigned exp_pulses;
        int unsigned exp_rels;
        int unsigned exp_first;   // segment edge of first strobe, 0 = none
        logic        exp_level;
    } seg_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Scoreboard: expected outputs per edge, pushed when the sample is taken.
    out_t sb_q[$];

    // Reference model state (sample-run based).
    logic        level_m;
    int unsigned run_m;
    logic        prev_p_m;
    int unsigned held_t;

    // Per-segment observation.
    int unsigned seg_edge;
    int unsigned seg_pulses;
    int unsigned seg_rels;
    int unsigned seg_first;
    int unsigned pulse_edges[$];

    seg_t tbl[11];

    task automatic model_reset();
        level_m  = 1'b0;
        run_m    = 0;
        prev_p_m = 1'b0;
        held_t   = 0;
        sb_q.delete();
        sb_q.push_back(out_t'(3'b000));
        sb_q.push_back(out_t'(3'b000));
    endtask

    // A level change needs D+1 consecutive opposite samples; its effect shows
    // two edges after the last of them.
    task automatic model_sample(input logic k);
        logic pressed;
        logic held_edge;
        out_t e;
        pressed   = ~k;
        held_edge = level_m && prev_p_m;
        e         = '0;
        if (pressed != level_m) begin
            run_m++;
            if (run_m == D + 1) begin
                level_m = pressed;
                run_m   = 0;
                if (pressed) begin
                    e.p    = 1'b1;
                    held_t = 0;
                end else begin
                    e.r = 1'b1;
                end
            end
        end else begin
            run_m = 0;
        end
`ifdef KEY_AUTOREPEAT_EN
        if (held_edge) begin
            held_t++;
            if (held_t == RD || (held_t > RD && (held_t - RD) % RP == 0))
                e.p = 1'b1;
        end
`else
        if (held_edge) held_t++;
`endif
        e.l      = level_m;
        prev_p_m = pressed;
        sb_q.push_back(e);
    endtask

    task automatic seg_begin();
        seg_edge   = 0;
        seg_pulses = 0;
        seg_rels   = 0;
        seg_first  = 0;
        pulse_edges.delete();
    endtask

    task automatic compare();
        out_t a;
        out_t e;
        a = '{Level, Pulse, Release};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow at edge %0d: no expected entry", seg_edge);
        end else begin
            e = sb_q.pop_front();
            if (a !== e)  begin
                errors++;
                $display("FAIL cycle_out t=%0t edge %0d: got L/P/R=%b%b%b want %b%b%b",
                         $time, seg_edge, a.l, a.p, a.r, e.l, e.p, e.r);
            end
        end
        if (Pulse === 1'b1) begin
            seg_pulses++;
            pulse_edges.push_back(seg_edge);
        end
        if (Release === 1'b1) seg_rels++;
        if ((Pulse === 1'b1 || Release === 1'b1) && seg_first == 0)
            seg_first = seg_edge;
    endtask

    // Drive at the falling edge, sample model at the rising edge, compare #1 later.
    task automatic step(input logic k);
        KeyN = k;
        @(posedge Clk);
        model_sample(k);
        #1;
        seg_edge++;
        compare();
        @(negedge Clk);
    endtask

    task automatic check_int(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_out(input string name, input out_t want);
        out_t a;
        a = '{Level, Pulse, Release};
        checks++;
        if (a !== want) begin
            errors++;
            $display("FAIL %s: got L/P/R=%b%b%b want %b%b%b",
                     name, a.l, a.p, a.r, want.l, want.p, want.r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int unsigned exp_rep[$];

        tbl[0]  = '{1'b1, 10, 0, 0, 0, 1'b0};   // idle after reset
        tbl[1]  = '{1'b0, 20, 1, 0, 7, 1'b1};   // clean press
        tbl[2]  = '{1'b1, 20, 0, 1, 7, 1'b0};   // clean release
        tbl[3]  = '{1'b0,  3, 0, 0, 0, 1'b0};   // bounce
        tbl[4]  = '{1'b1,  2, 0, 0, 0, 1'b0};
        tbl[5]  = '{1'b0,  3, 0, 0, 0, 1'b0};
        tbl[6]  = '{1'b1, 10, 0, 0, 0, 1'b0};
        tbl[7]  = '{1'b0, 10, 1, 0, 7, 1'b1};   // press, then release glitch
        tbl[8]  = '{1'b1,  2, 0, 0, 0, 1'b1};
        tbl[9]  = '{1'b0,  5, 0, 0, 0, 1'b1};
        tbl[10] = '{1'b1, 10, 0, 1, 7, 1'b0};   // genuine release

        Clr  = 1'b1;
        KeyN = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_out("reset_state", out_t'(3'b000));
        @(negedge Clk);
        Clr = 1'b0;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            seg_begin();
            for (int unsigned c = 0; c < tbl[i].cycles; c++) step(tbl[i].keyn);
            check_int($sformatf("seg%0d_pulses", i), seg_pulses, tbl[i].exp_pulses);
            check_int($sformatf("seg%0d_releases", i), seg_rels, tbl[i].exp_rels);
            check_int($sformatf("seg%0d_first_edge", i), seg_first, tbl[i].exp_first);
            check_int($sformatf("seg%0d_level", i), int'(Level), int'(tbl[i].exp_level));
        end

        // Asynchronous clear while HELD, key kept low through deassertion.
        seg_begin();
        for (int c = 0; c < 10; c++) step(1'b0);
        check_int("pre_clr_level", int'(Level), 1);
        #2;
        Clr = 1'b1;
        #1;
        check_out("async_clr", out_t'(3'b000));
        @(posedge Clk);
        #1;
        check_out("clr_held", out_t'(3'b000));
        @(negedge Clk);
        Clr = 1'b0;
        model_reset();
        seg_begin();
        for (int c = 0; c < 12; c++) step(1'b0);
        check_int("post_clr_pulses", seg_pulses, 1);
        check_int("post_clr_first_edge", seg_first, 7);
        check_int("post_clr_releases", seg_rels, 0);
        seg_begin();
        for (int c = 0; c < 10; c++) step(1'b1);
        check_int("post_clr_release", seg_rels, 1);

        // Long hold: 7 edges to acceptance plus 40 held cycles.
`ifdef KEY_AUTOREPEAT_EN
        exp_rep = '{7, 27, 33, 39, 45};
`else
        exp_rep = '{7};
`endif
        seg_begin();
        for (int c = 0; c < 47; c++) step(1'b0);
        check_int("hold_pulse_count", pulse_edges.size(), exp_rep.size());
        for (int i = 0; i < exp_rep.size() && i < pulse_edges.size(); i++)
            check_int($sformatf("hold_pulse%0d_edge", i), pulse_edges[i], exp_rep[i]);
        seg_begin();
        for (int c = 0; c < 10; c++) step(1'b1);
        check_int("hold_release", seg_rels, 1);
        check_int("hold_release_edge", seg_first, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
